sdp_x_x_trt_core_chn_in_rsci_chn_in_wait_ctrl_dp: RTL and testbench
===================================================================

Name: sdp_x_x_trt_core_chn_in_rsci_chn_in_wait_ctrl_dp

Overview:
- Receive-side counterpart of the SDP X trt core output-channel wait control.
- Handles the input-channel handshake (valid/ready) into the SDP X trt core.
- Holds a pending read request across core stalls, and captures upstream data into a one-entry buffer when it arrives while the core is stalled.
- Muxes buffered or live data to the core and generates the completion signal that releases core stall.

Parameters:
- DW, 32, width of chn_in data word.

Ports:
- nvdla_core_clk  input  1  clock; all state on rising edge.
- nvdla_core_rstn  input  1  reset, asynchronous, active-low.
- chn_in_rsci_oswt  input  1  core operation switch: core wants a word this cycle.
- core_wen  input  1  core write/advance enable (core not stalled).
- core_wten  input  1  core stall-in-progress qualifier.
- chn_in_rsci_iswt0  input  1  core issues a read request.
- chn_in_rsci_ld_core_psct  input  1  pre-scheduled load enable from core.
- chn_in_rsci_vd  input  1  upstream data valid.
- chn_in_rsci_d  input  DW  upstream data.
- chn_in_rsci_ld_core_sct  output  1  ready to upstream.
- chn_in_rsci_biwt  output  1  transfer occurs this cycle.
- chn_in_rsci_bdwt  output  1  core consumes word this cycle.
- chn_in_rsci_wen_comp  output  1  input side complete; core may advance.
- chn_in_rsci_d_mxwt  output  DW  data presented to core.
- chn_in_rsci_ovf_err  output  1  sticky error: transfer accepted while buffer full.

Behaviour:
- Combinational terms:
  - pdswt0 = iswt0 & ~core_wten.
  - ogwt = pdswt0 | icwt.
  - ld_core_sct = ld_core_psct & ogwt.
  - biwt = ogwt & vd.
  - bdwt = oswt & core_wen.
  - wen_comp = ~oswt | biwt | bcwt.
  - d_mxwt = bcwt ? d_bfwt : d.
- State, all async reset to 0:
  - icwt (request pending): next = ogwt & ~biwt.
  - bcwt (buffer valid): next = (bcwt | biwt) & ~bdwt.
  - d_bfwt[DW-1:0]: loads d when biwt, else holds.
  - ovf_err: set when biwt & bcwt & ~bdwt; cleared only by reset.
- Reset state: icwt=0, bcwt=0, d_bfwt=0, ovf_err=0.
  - Outputs under reset: ld_core_sct, biwt, bdwt, d_mxwt follow inputs combinationally (d_mxwt = d since bcwt=0).
  - wen_comp = ~oswt.
- Latency:
  - Zero cycles when vd is present with the request: biwt and wen_comp in the same cycle, data passes through on d_mxwt.
  - A stalled request is retried every cycle via icwt until vd.
- Simultaneous events:
  - biwt & bdwt in the same cycle: bcwt next = 0; the word goes straight through and is not held.
  - bcwt=1 & bdwt: d_mxwt = d_bfwt that cycle, then the buffer empties.
  - iswt0 while core_wten=1 with icwt=0: no request issued (ogwt=0, ld_core_sct=0).
- Reset mid-operation: pending request and buffered word are dropped; no partial transfer is reported after reset release.
- Protocol rule: upstream may drop d only after biwt. The block never asserts ld_core_sct without ogwt.

Test Plan:
- Reset, then iswt0=1, core_wten=0, vd=1, d=0xA5A5_0001, oswt=1, core_wen=1 -> same cycle: ld_core_sct=1, biwt=1, wen_comp=1, d_mxwt=0xA5A5_0001. Next cycle: icwt=0, bcwt=0.
- iswt0=1 with vd=0 for 3 cycles, then vd=1 with d=0x0000_00FF -> icwt=1 for cycles 2-4, biwt=1 on cycle 4, then icwt=0.
- Transfer d=0x1234_5678 with oswt=1, core_wen=0 -> bcwt=1. Upstream then drives d=0xDEAD_BEEF, and d_mxwt stays 0x1234_5678. When core_wen=1: bdwt=1, and next cycle bcwt=0.
- bcwt=1 and a new biwt with bdwt=0 -> ovf_err=1 next cycle and stays 1 until reset.
- Assert nvdla_core_rstn=0 with icwt=1, bcwt=1 -> icwt, bcwt, d_bfwt, ovf_err all 0 asynchronously. wen_comp = ~oswt.
- core_wten=1, iswt0=1, icwt=0, vd=1 -> ld_core_sct=0, biwt=0, no state change.

Source files
------------

// File: rtl/sdp_x_x_trt_core_chn_in_rsci_chn_in_wait_ctrl_dp_if.sv
// Input-channel handshake bundle between upstream, the SDP X trt core and
// the chn_in wait-control datapath.
//   slave  : the wait-control datapath (consumes core/upstream controls,
//            produces ready, transfer strobes, completion and muxed data)
//   master : the environment driving the core controls and upstream data
interface sdp_x_x_trt_core_chn_in_rsci_chn_in_wait_ctrl_dp_if #(
  parameter int DW = 32
);
  logic          chn_in_rsci_oswt;
  logic          core_wen;
  logic          core_wten;
  logic          chn_in_rsci_iswt0;
  logic          chn_in_rsci_ld_core_psct;
  logic          chn_in_rsci_vd;
  logic [DW-1:0] chn_in_rsci_d;
  logic          chn_in_rsci_ld_core_sct;
  logic          chn_in_rsci_biwt;
  logic          chn_in_rsci_bdwt;
  logic          chn_in_rsci_wen_comp;
  logic [DW-1:0] chn_in_rsci_d_mxwt;
  logic          chn_in_rsci_ovf_err;

  modport slave (
    input  chn_in_rsci_oswt, core_wen, core_wten, chn_in_rsci_iswt0,
           chn_in_rsci_ld_core_psct, chn_in_rsci_vd, chn_in_rsci_d,
    output chn_in_rsci_ld_core_sct, chn_in_rsci_biwt, chn_in_rsci_bdwt,
           chn_in_rsci_wen_comp, chn_in_rsci_d_mxwt, chn_in_rsci_ovf_err
  );

  modport master (
    output chn_in_rsci_oswt, core_wen, core_wten, chn_in_rsci_iswt0,
           chn_in_rsci_ld_core_psct, chn_in_rsci_vd, chn_in_rsci_d,
    input  chn_in_rsci_ld_core_sct, chn_in_rsci_biwt, chn_in_rsci_bdwt,
           chn_in_rsci_wen_comp, chn_in_rsci_d_mxwt, chn_in_rsci_ovf_err
  );
endinterface

// File: rtl/sdp_x_x_trt_core_chn_in_rsci_chn_in_wait_ctrl_dp.sv
// Input-channel wait control for the SDP X trt core.
// Holds a read request pending across core stalls, captures an upstream word
// into a one-entry buffer when it arrives while the core cannot consume it,
// presents buffered or live data to the core and raises wen_comp to release
// the core stall.
// Ports:
//   nvdla_core_clk  : clock, all state on rising edge
//   nvdla_core_rstn : asynchronous active-low reset
//   chn             : handshake bundle (slave modport), see the _if file
module sdp_x_x_trt_core_chn_in_rsci_chn_in_wait_ctrl_dp #(
  parameter int DW = 32
) (
  input  logic nvdla_core_clk,
  input  logic nvdla_core_rstn,
  sdp_x_x_trt_core_chn_in_rsci_chn_in_wait_ctrl_dp_if.slave chn
);

  logic          icwt;     // read request pending
  logic          bcwt;     // buffer holds a word not yet consumed
  logic [DW-1:0] d_bfwt;   // one-entry capture buffer
  logic          ovf_err;

  logic pdswt0;
  logic ogwt;
  logic biwt;
  logic bdwt;

  // A fresh request is suppressed while the core is mid-stall; a request
  // already pending keeps retrying every cycle until upstream is valid.
  assign pdswt0 = chn.chn_in_rsci_iswt0 & ~chn.core_wten;
  assign ogwt   = pdswt0 | icwt;
  assign biwt   = ogwt & chn.chn_in_rsci_vd;
  assign bdwt   = chn.chn_in_rsci_oswt & chn.core_wen;

  assign chn.chn_in_rsci_ld_core_sct = chn.chn_in_rsci_ld_core_psct & ogwt;
  assign chn.chn_in_rsci_biwt        = biwt;
  assign chn.chn_in_rsci_bdwt        = bdwt;
  assign chn.chn_in_rsci_wen_comp    = ~chn.chn_in_rsci_oswt | biwt | bcwt;
  assign chn.chn_in_rsci_d_mxwt      = bcwt ? d_bfwt : chn.chn_in_rsci_d;
  assign chn.chn_in_rsci_ovf_err     = ovf_err;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      icwt    <= 1'b0;
      bcwt    <= 1'b0;
      d_bfwt  <= '0;
      ovf_err <= 1'b0;
    end else begin
      icwt <= ogwt & ~biwt;
      // A word arriving in the same cycle the core consumes passes straight
      // through and is not held.
      bcwt <= (bcwt | biwt) & ~bdwt;
      if (biwt) begin
        d_bfwt <= chn.chn_in_rsci_d;
      end
      // Overwriting an unconsumed buffered word loses data; flag it sticky.
      if (biwt & bcwt & ~bdwt) begin
        ovf_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sdp_x_x_trt_core_chn_in_rsci_chn_in_wait_ctrl_dp.sv
module tb_sdp_x_x_trt_core_chn_in_rsci_chn_in_wait_ctrl_dp;
  localparam int DW = 32;

  logic nvdla_core_clk = 1'b0;
  logic nvdla_core_rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  sdp_x_x_trt_core_chn_in_rsci_chn_in_wait_ctrl_dp_if #(.DW(DW)) bus ();

  sdp_x_x_trt_core_chn_in_rsci_chn_in_wait_ctrl_dp #(.DW(DW)) dut (
    .nvdla_core_clk (nvdla_core_clk),
    .nvdla_core_rstn(nvdla_core_rstn),
    .chn            (bus.slave)
  );

  always #5 nvdla_core_clk = ~nvdla_core_clk;

  task automatic drive(input logic oswt, input logic wen, input logic wten,
                       input logic iswt0, input logic psct, input logic vd,
                       input logic [DW-1:0] d);
    bus.chn_in_rsci_oswt         = oswt;
    bus.core_wen                 = wen;
    bus.core_wten                = wten;
    bus.chn_in_rsci_iswt0        = iswt0;
    bus.chn_in_rsci_ld_core_psct = psct;
    bus.chn_in_rsci_vd           = vd;
    bus.chn_in_rsci_d            = d;
    #2;
  endtask

  task automatic tick();
    @(posedge nvdla_core_clk);
    #1;
  endtask

  task automatic test_reset();
    nvdla_core_rstn = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 32'h0000_0055);
    checks++; if (dut.icwt !== 1'b0) begin errors++; $display("FAIL rst_icwt got %b exp 0", dut.icwt); end
    checks++; if (dut.bcwt !== 1'b0) begin errors++; $display("FAIL rst_bcwt got %b exp 0", dut.bcwt); end
    checks++; if (dut.d_bfwt !== 32'h0) begin errors++; $display("FAIL rst_d_bfwt got %h exp 0", dut.d_bfwt); end
    checks++; if (bus.chn_in_rsci_ovf_err !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b exp 0", bus.chn_in_rsci_ovf_err); end
    checks++; if (bus.chn_in_rsci_wen_comp !== 1'b0) begin errors++; $display("FAIL rst_wen_comp_oswt1 got %b exp 0", bus.chn_in_rsci_wen_comp); end
    checks++; if (bus.chn_in_rsci_d_mxwt !== 32'h0000_0055) begin errors++; $display("FAIL rst_d_mxwt got %h exp 00000055", bus.chn_in_rsci_d_mxwt); end
    drive(0, 0, 0, 0, 0, 0, 32'h0);
    checks++; if (bus.chn_in_rsci_wen_comp !== 1'b1) begin errors++; $display("FAIL rst_wen_comp_oswt0 got %b exp 1", bus.chn_in_rsci_wen_comp); end
    @(negedge nvdla_core_clk);
    nvdla_core_rstn = 1'b1;
    tick();
  endtask

  task automatic test_pass_through();
    drive(1, 1, 0, 1, 1, 1, 32'hA5A5_0001);
    checks++; if (bus.chn_in_rsci_ld_core_sct !== 1'b1) begin errors++; $display("FAIL pt_ld_core_sct got %b exp 1", bus.chn_in_rsci_ld_core_sct); end
    checks++; if (bus.chn_in_rsci_biwt !== 1'b1) begin errors++; $display("FAIL pt_biwt got %b exp 1", bus.chn_in_rsci_biwt); end
    checks++; if (bus.chn_in_rsci_bdwt !== 1'b1) begin errors++; $display("FAIL pt_bdwt got %b exp 1", bus.chn_in_rsci_bdwt); end
    checks++; if (bus.chn_in_rsci_wen_comp !== 1'b1) begin errors++; $display("FAIL pt_wen_comp got %b exp 1", bus.chn_in_rsci_wen_comp); end
    checks++; if (bus.chn_in_rsci_d_mxwt !== 32'hA5A5_0001) begin errors++; $display("FAIL pt_d_mxwt got %h exp a5a50001", bus.chn_in_rsci_d_mxwt); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 32'h0);
    checks++; if (dut.icwt !== 1'b0) begin errors++; $display("FAIL pt_icwt_next got %b exp 0", dut.icwt); end
    checks++; if (dut.bcwt !== 1'b0) begin errors++; $display("FAIL pt_bcwt_next got %b exp 0", dut.bcwt); end
    tick();
  endtask

  task automatic test_stall_retry();
    drive(1, 1, 0, 1, 1, 0, 32'h0);
    checks++; if (bus.chn_in_rsci_wen_comp !== 1'b0) begin errors++; $display("FAIL sr_wen_comp_c1 got %b exp 0", bus.chn_in_rsci_wen_comp); end
    checks++; if (bus.chn_in_rsci_biwt !== 1'b0) begin errors++; $display("FAIL sr_biwt_c1 got %b exp 0", bus.chn_in_rsci_biwt); end
    for (int c = 2; c <= 3; c++) begin
      tick();
      checks++; if (dut.icwt !== 1'b1) begin errors++; $display("FAIL sr_icwt_c%0d got %b exp 1", c, dut.icwt); end
      checks++; if (bus.chn_in_rsci_biwt !== 1'b0) begin errors++; $display("FAIL sr_biwt_c%0d got %b exp 0", c, bus.chn_in_rsci_biwt); end
    end
    tick();
    drive(1, 1, 0, 1, 1, 1, 32'h0000_00FF);
    checks++; if (dut.icwt !== 1'b1) begin errors++; $display("FAIL sr_icwt_c4 got %b exp 1", dut.icwt); end
    checks++; if (bus.chn_in_rsci_biwt !== 1'b1) begin errors++; $display("FAIL sr_biwt_c4 got %b exp 1", bus.chn_in_rsci_biwt); end
    checks++; if (bus.chn_in_rsci_wen_comp !== 1'b1) begin errors++; $display("FAIL sr_wen_comp_c4 got %b exp 1", bus.chn_in_rsci_wen_comp); end
    checks++; if (bus.chn_in_rsci_d_mxwt !== 32'h0000_00FF) begin errors++; $display("FAIL sr_d_mxwt_c4 got %h exp 000000ff", bus.chn_in_rsci_d_mxwt); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 32'h0);
    checks++; if (dut.icwt !== 1'b0) begin errors++; $display("FAIL sr_icwt_c5 got %b exp 0", dut.icwt); end
    checks++; if (dut.bcwt !== 1'b0) begin errors++; $display("FAIL sr_bcwt_c5 got %b exp 0", dut.bcwt); end
    tick();
  endtask

  task automatic test_buffer_hold();
    drive(1, 0, 0, 1, 1, 1, 32'h1234_5678);
    checks++; if (bus.chn_in_rsci_biwt !== 1'b1) begin errors++; $display("FAIL bh_biwt got %b exp 1", bus.chn_in_rsci_biwt); end
    checks++; if (bus.chn_in_rsci_bdwt !== 1'b0) begin errors++; $display("FAIL bh_bdwt got %b exp 0", bus.chn_in_rsci_bdwt); end
    tick();
    drive(1, 0, 0, 0, 0, 0, 32'hDEAD_BEEF);
    checks++; if (dut.bcwt !== 1'b1) begin errors++; $display("FAIL bh_bcwt got %b exp 1", dut.bcwt); end
    checks++; if (bus.chn_in_rsci_d_mxwt !== 32'h1234_5678) begin errors++; $display("FAIL bh_d_mxwt_hold got %h exp 12345678", bus.chn_in_rsci_d_mxwt); end
    checks++; if (bus.chn_in_rsci_wen_comp !== 1'b1) begin errors++; $display("FAIL bh_wen_comp got %b exp 1", bus.chn_in_rsci_wen_comp); end
    tick();
    drive(1, 0, 0, 0, 0, 0, 32'hDEAD_BEEF);
    checks++; if (bus.chn_in_rsci_d_mxwt !== 32'h1234_5678) begin errors++; $display("FAIL bh_d_mxwt_hold2 got %h exp 12345678", bus.chn_in_rsci_d_mxwt); end
    drive(1, 1, 0, 0, 0, 0, 32'hDEAD_BEEF);
    checks++; if (bus.chn_in_rsci_bdwt !== 1'b1) begin errors++; $display("FAIL bh_bdwt_release got %b exp 1", bus.chn_in_rsci_bdwt); end
    checks++; if (bus.chn_in_rsci_d_mxwt !== 32'h1234_5678) begin errors++; $display("FAIL bh_d_mxwt_consume got %h exp 12345678", bus.chn_in_rsci_d_mxwt); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF);
    checks++; if (dut.bcwt !== 1'b0) begin errors++; $display("FAIL bh_bcwt_empty got %b exp 0", dut.bcwt); end
    checks++; if (bus.chn_in_rsci_d_mxwt !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bh_d_mxwt_live got %h exp deadbeef", bus.chn_in_rsci_d_mxwt); end
    checks++; if (bus.chn_in_rsci_ovf_err !== 1'b0) begin errors++; $display("FAIL bh_ovf got %b exp 0", bus.chn_in_rsci_ovf_err); end
    tick();
  endtask

  task automatic test_overflow();
    drive(1, 0, 0, 1, 1, 1, 32'h1111_1111);
    tick();
    drive(1, 0, 0, 1, 1, 1, 32'h2222_2222);
    checks++; if (bus.chn_in_rsci_ovf_err !== 1'b0) begin errors++; $display("FAIL ov_before got %b exp 0", bus.chn_in_rsci_ovf_err); end
    tick();
    drive(1, 1, 0, 0, 0, 0, 32'h0);
    checks++; if (bus.chn_in_rsci_ovf_err !== 1'b1) begin errors++; $display("FAIL ov_set got %b exp 1", bus.chn_in_rsci_ovf_err); end
    checks++; if (dut.d_bfwt !== 32'h2222_2222) begin errors++; $display("FAIL ov_d_bfwt got %h exp 22222222", dut.d_bfwt); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 32'h0);
    tick();
    tick();
    checks++; if (dut.bcwt !== 1'b0) begin errors++; $display("FAIL ov_bcwt_drained got %b exp 0", dut.bcwt); end
    checks++; if (bus.chn_in_rsci_ovf_err !== 1'b1) begin errors++; $display("FAIL ov_sticky got %b exp 1", bus.chn_in_rsci_ovf_err); end
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 0, 1, 1, 1, 32'h3333_3333);
    tick();
    drive(1, 0, 0, 1, 1, 0, 32'h0);
    tick();
    checks++; if (dut.icwt !== 1'b1 || dut.bcwt !== 1'b1) begin errors++; $display("FAIL rm_setup got icwt=%b bcwt=%b exp 1 1", dut.icwt, dut.bcwt); end
    #2;
    nvdla_core_rstn = 1'b0;
    #1;
    checks++; if (dut.icwt !== 1'b0) begin errors++; $display("FAIL rm_icwt got %b exp 0", dut.icwt); end
    checks++; if (dut.bcwt !== 1'b0) begin errors++; $display("FAIL rm_bcwt got %b exp 0", dut.bcwt); end
    checks++; if (dut.d_bfwt !== 32'h0) begin errors++; $display("FAIL rm_d_bfwt got %h exp 0", dut.d_bfwt); end
    checks++; if (bus.chn_in_rsci_ovf_err !== 1'b0) begin errors++; $display("FAIL rm_ovf got %b exp 0", bus.chn_in_rsci_ovf_err); end
    checks++; if (bus.chn_in_rsci_wen_comp !== 1'b0) begin errors++; $display("FAIL rm_wen_comp got %b exp 0", bus.chn_in_rsci_wen_comp); end
    drive(0, 0, 0, 0, 0, 0, 32'h0);
    @(negedge nvdla_core_clk);
    nvdla_core_rstn = 1'b1;
    tick();
    checks++; if (dut.icwt !== 1'b0 || dut.bcwt !== 1'b0) begin errors++; $display("FAIL rm_after got icwt=%b bcwt=%b exp 0 0", dut.icwt, dut.bcwt); end
    checks++; if (bus.chn_in_rsci_biwt !== 1'b0) begin errors++; $display("FAIL rm_biwt_after got %b exp 0", bus.chn_in_rsci_biwt); end
  endtask

  task automatic test_wten_block();
    drive(0, 0, 1, 1, 1, 1, 32'h0000_0077);
    checks++; if (bus.chn_in_rsci_ld_core_sct !== 1'b0) begin errors++; $display("FAIL wt_ld_core_sct got %b exp 0", bus.chn_in_rsci_ld_core_sct); end
    checks++; if (bus.chn_in_rsci_biwt !== 1'b0) begin errors++; $display("FAIL wt_biwt got %b exp 0", bus.chn_in_rsci_biwt); end
    tick();
    checks++; if (dut.icwt !== 1'b0 || dut.bcwt !== 1'b0) begin errors++; $display("FAIL wt_state got icwt=%b bcwt=%b exp 0 0", dut.icwt, dut.bcwt); end
    checks++; if (dut.d_bfwt !== 32'h0) begin errors++; $display("FAIL wt_d_bfwt got %h exp 0", dut.d_bfwt); end
    drive(0, 0, 0, 0, 0, 0, 32'h0);
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_stall_retry();
    test_buffer_hold();
    test_overflow();
    test_reset_mid();
    test_wten_block();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end
endmodule
